// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: shares the RTC bus engine between init, user and reader requesters with timeout guard
module rtc_bus_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255,
  parameter logic [3:0] MAX_SKIP = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_valid,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wdata,
  output logic       init_done,
  input  logic       user_valid,
  input  logic [7:0] user_addr,
  input  logic [7:0] user_wdata,
  output logic       user_done,
  input  logic       rd_valid,
  input  logic [7:0] rd_addr,
  output logic       rd_done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       bus_start,
  output logic       bus_write,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic [1:0] grant_id
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RELEASE = 2'd3;
  logic [1:0] state;
  logic [1:0] win;
  logic [3:0] skip_cnt;
  logic [7:0] wait_cnt;
  logic       finish;
  // a starved reader overrides the fixed priority
  always_comb begin
    win = (rd_valid && skip_cnt == MAX_SKIP) ? 2'd3 :
          init_valid ? 2'd1 :
          user_valid ? 2'd2 :
          rd_valid ? 2'd3 : 2'd0;
    finish = bus_done || wait_cnt == TIMEOUT_CYCLES - 8'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      skip_cnt <= 4'd0;
      wait_cnt <= 8'd0;
      init_done <= 1'b0;
      user_done <= 1'b0;
      rd_done <= 1'b0;
      rdata <= 8'h00;
      err <= 1'b0;
      bus_start <= 1'b0;
      bus_write <= 1'b0;
      bus_addr <= 8'h00;
      bus_wdata <= 8'h00;
      grant_id <= 2'd0;
    end else begin
      case (state)
        IDLE: if (win != 2'd0) begin
          bus_start <= 1'b1;
          grant_id <= win;
          bus_write <= win != 2'd3;
          bus_addr <= win == 2'd1 ? init_addr : win == 2'd2 ? user_addr : rd_addr;
          bus_wdata <= win == 2'd1 ? init_wdata : win == 2'd2 ? user_wdata : 8'h00;
          skip_cnt <= win == 2'd3 ? 4'd0 :
                      (rd_valid && skip_cnt < MAX_SKIP) ? skip_cnt + 4'd1 : skip_cnt;
          state <= ISSUE;
        end
        ISSUE: begin
          bus_start <= 1'b0;
          wait_cnt <= 8'd0;
          state <= WAIT;
        end
        WAIT: if (finish) begin
          err <= !bus_done;
          init_done <= grant_id == 2'd1;
          user_done <= grant_id == 2'd2;
          rd_done <= grant_id == 2'd3;
          if (bus_done && grant_id == 2'd3) rdata <= bus_rdata;
          state <= RELEASE;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
        default: begin
          init_done <= 1'b0;
          user_done <= 1'b0;
          rd_done <= 1'b0;
          err <= 1'b0;
          grant_id <= 2'd0;
          bus_write <= 1'b0;
          bus_addr <= 8'h00;
          bus_wdata <= 8'h00;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: randomized requesters and engine checked against a transaction-level model
module tb_rtc_bus_arbiter;
  logic clk = 0, reset = 1;
  logic init_valid = 0, user_valid = 0, rd_valid = 0, bus_done = 0;
  logic [7:0] init_addr = 0, init_wdata = 0, user_addr = 0, user_wdata = 0, rd_addr = 0, bus_rdata = 0;
  logic init_done, user_done, rd_done, err, bus_start, bus_write;
  logic [7:0] rdata, bus_addr, bus_wdata;
  logic [1:0] grant_id;
  int checks = 0, errors = 0;
  bit pend [1:3];
  logic [7:0] p_addr [1:3];
  logic [7:0] p_data [1:3];
  int skip = 0;
  logic [7:0] rdata_exp = 0;

  rtc_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .init_valid(init_valid), .init_addr(init_addr), .init_wdata(init_wdata), .init_done(init_done),
    .user_valid(user_valid), .user_addr(user_addr), .user_wdata(user_wdata), .user_done(user_done),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_done(rd_done), .rdata(rdata), .err(err),
    .bus_start(bus_start), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_done(bus_done), .bus_rdata(bus_rdata), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    init_valid = pend[1]; init_addr = p_addr[1]; init_wdata = p_data[1];
    user_valid = pend[2]; user_addr = p_addr[2]; user_wdata = p_data[2];
    rd_valid = pend[3]; rd_addr = p_addr[3];
  endtask

  task automatic request(input int i, input logic [7:0] a, input logic [7:0] d);
    pend[i] = 1; p_addr[i] = a; p_data[i] = d;
  endtask

  function automatic int pick();
    if (pend[3] && skip == 3) return 3;
    for (int i = 1; i <= 3; i++) if (pend[i]) return i;
    return 0;
  endfunction

  task automatic check_idle(input string tag);
    chk(tag, {init_done, user_done, rd_done, err, bus_start, bus_write, grant_id, bus_addr, bus_wdata}, 0);
    chk({tag, "_rdata"}, rdata, rdata_exp);
  endtask

  // called at a negedge in IDLE with at least one request pending; ends at the following IDLE negedge
  task automatic do_txn(input int d, input bit hang, input bit noise, input logic [7:0] rv);
    int w, t;
    logic [7:0] ea, ed;
    w = pick();
    ea = p_addr[w];
    ed = (w == 3) ? 8'h00 : p_data[w];
    if (w == 3) skip = 0;
    else if (pend[3] && skip < 3) skip++;
    drive_reqs();
    bus_done = 0;
    @(negedge clk);
    chk("start", bus_start, 1);
    chk("grant", grant_id, w);
    chk("write", bus_write, w != 3);
    chk("addr", bus_addr, ea);
    chk("wdata", bus_wdata, ed);
    p_addr[w] = 8'($urandom); p_data[w] = 8'($urandom);
    drive_reqs();
    bus_done = noise;
    bus_rdata = 8'($urandom);
    t = hang ? 254 : d;
    for (int c = 0; c <= t; c++) begin
      @(negedge clk);
      chk("wait_quiet", {bus_start, init_done, user_done, rd_done, err}, 0);
      bus_done = !hang && c == t;
      bus_rdata = (c == t) ? rv : 8'($urandom);
    end
    @(negedge clk);
    bus_done = 0;
    if (!hang && w == 3) rdata_exp = rv;
    chk("done", {init_done, user_done, rd_done}, 32'(3'b100 >> (w - 1)));
    chk("err", err, hang);
    chk("rdata", rdata, rdata_exp);
    chk("grant_hold", grant_id, w);
    chk("addr_hold", bus_addr, ea);
    pend[w] = 0;
    drive_reqs();
    @(negedge clk);
    check_idle("release");
  endtask

  initial begin
    for (int i = 1; i <= 3; i++) begin pend[i] = 0; p_addr[i] = 0; p_data[i] = 0; end
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 0;
    @(negedge clk);
    check_idle("post_reset");
    request(3, 8'h21, 8'h00);
    do_txn(2, 0, 0, 8'h45);
    request(1, 8'h10, 8'hA1); request(2, 8'h20, 8'hB2); request(3, 8'h30, 8'h00);
    repeat (3) do_txn(1, 0, 0, 8'h5C);
    request(2, 8'h40, 8'h11); request(3, 8'h50, 8'h00);
    for (int k = 0; k < 4; k++) begin
      if (!pend[2]) request(2, 8'(8'h41 + k), 8'(8'h12 + k));
      do_txn(0, 0, k == 0, 8'h77);
    end
    if (pend[2]) do_txn(0, 0, 0, 8'h00);
    request(3, 8'h60, 8'h00);
    do_txn(0, 1, 0, 8'h99);
    request(3, 8'h61, 8'h00);
    do_txn(254, 0, 0, 8'hC3);
    request(1, 8'h62, 8'h3C);
    do_txn(0, 1, 0, 8'h00);
    for (int n = 0; n < 60; n++) begin
      for (int i = 1; i <= 3; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) request(i, 8'($urandom), 8'($urandom));
      if (pick() == 0) begin
        drive_reqs();
        @(negedge clk);
        check_idle("idle_stay");
      end else begin
        do_txn($urandom_range(0, 6), $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
      end
    end
    for (int i = 1; i <= 3; i++) pend[i] = 0;
    request(3, 8'h70, 8'h00);
    do_txn(1, 0, 0, 8'hE7);
    request(2, 8'h80, 8'h5A);
    drive_reqs();
    repeat (3) @(negedge clk);
    chk("pre_reset_grant", grant_id, 2);
    reset = 1;
    @(negedge clk);
    rdata_exp = 0; skip = 0; pend[2] = 0;
    drive_reqs();
    check_idle("mid_reset");
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      check_idle("no_done_after_reset");
    end
    request(1, 8'h90, 8'hC5);
    do_txn(3, 0, 0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
